// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between the ALU (A) and
// load (M) writeback sources, with a registered write stage and a RAW busy scoreboard.
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     a_valid,
    output logic                     a_ready,
    input  logic [ADDR_W-1:0]        a_rd,
    input  logic [DATA_W-1:0]        a_wd,
    input  logic                     m_valid,
    output logic                     m_ready,
    input  logic [ADDR_W-1:0]        m_rd,
    input  logic [DATA_W-1:0]        m_wd,
    input  logic                     issue_valid,
    input  logic [ADDR_W-1:0]        issue_rd,
    output logic [(1<<ADDR_W)-1:0]   busy_mask,
    output logic                     rf_we,
    output logic [ADDR_W-1:0]        rf_rd,
    output logic [DATA_W-1:0]        rf_wd
);

    localparam int NREG = 1 << ADDR_W;

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_M = 1'b1
    } grant_t;

    grant_t            last_grant;
    logic              xfer_p0;
    logic              wr_p0;
    logic [ADDR_W-1:0] sel_rd_p0;
    logic [DATA_W-1:0] sel_wd_p0;
    logic [NREG-1:0]   busy_next;

    // On a tie the source that did not win last time is granted.
    always_comb begin
        a_ready = 1'b0;
        m_ready = 1'b0;
        if (!rst) begin
            if (a_valid && (!m_valid || last_grant == GRANT_M)) begin
                a_ready = 1'b1;
            end else if (m_valid) begin
                m_ready = 1'b1;
            end
        end
    end

    always_comb begin
        xfer_p0   = a_ready | m_ready;
        sel_rd_p0 = a_ready ? a_rd : m_rd;
        sel_wd_p0 = a_ready ? a_wd : m_wd;
        wr_p0     = xfer_p0 && (sel_rd_p0 != '0);
    end

    // Clear for the retiring write first, then set for the new issue so set wins.
    always_comb begin
        busy_next = busy_mask;
        if (wr_p0) begin
            busy_next[sel_rd_p0] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // ---- stage p0 -> p1: arbitration result registered onto the write port ----
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= GRANT_M;
            rf_we      <= 1'b0;
            rf_rd      <= '0;
            rf_wd      <= '0;
            busy_mask  <= '0;
        end else begin
            if (a_ready) begin
                last_grant <= GRANT_A;
            end else if (m_ready) begin
                last_grant <= GRANT_M;
            end
            rf_we <= wr_p0;
            if (wr_p0) begin
                rf_rd <= sel_rd_p0;
                rf_wd <= sel_wd_p0;
            end
            busy_mask <= busy_next;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, single source, contention,
// x0 writes, scoreboard set/clear priority and reset in mid-flight.
module tb_regfile_wb_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              a_valid, m_valid, issue_valid;
    logic              a_ready, m_ready;
    logic [ADDR_W-1:0] a_rd, m_rd, issue_rd;
    logic [DATA_W-1:0] a_wd, m_wd;
    logic [31:0]       busy_mask;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_rd;
    logic [DATA_W-1:0] rf_wd;

    int pass_cnt = 0;
    int total_cnt = 0;

    regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_wd(a_wd),
        .m_valid(m_valid), .m_ready(m_ready), .m_rd(m_rd), .m_wd(m_wd),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .busy_mask(busy_mask),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_valid = 1'b0; m_valid = 1'b0; issue_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_valid = 1'b1; a_rd = 5'd1; a_wd = 32'h1111_1111;
        m_valid = 1'b1; m_rd = 5'd2; m_wd = 32'h2222_2222;
        issue_valid = 1'b1; issue_rd = 5'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            total_cnt++;
            if (a_ready !== 1'b0) $display("FAIL reset_a_ready cyc%0d got %b want 0", i, a_ready);
            else pass_cnt++;
            total_cnt++;
            if (m_ready !== 1'b0) $display("FAIL reset_m_ready cyc%0d got %b want 0", i, m_ready);
            else pass_cnt++;
        end
        total_cnt++;
        if (rf_we !== 1'b0) $display("FAIL reset_rf_we got %b want 0", rf_we);
        else pass_cnt++;
        total_cnt++;
        if (busy_mask !== 32'h0) $display("FAIL reset_busy got %h want 0", busy_mask);
        else pass_cnt++;
        total_cnt++;
        if (rf_rd !== 5'd0 || rf_wd !== 32'h0)
            $display("FAIL reset_rf_addr_data got %0d/%h want 0/0", rf_rd, rf_wd);
        else pass_cnt++;
        rst = 1'b0;
        idle_inputs();
        tick();
    endtask

    task automatic test_single();
        a_valid = 1'b1; a_rd = 5'd5; a_wd = 32'hDEAD_BEEF;
        #1;
        total_cnt++;
        if (a_ready !== 1'b1 || m_ready !== 1'b0)
            $display("FAIL single_ready got a=%b m=%b want a=1 m=0", a_ready, m_ready);
        else pass_cnt++;
        tick();
        a_valid = 1'b0;
        total_cnt++;
        if (rf_we !== 1'b1 || rf_rd !== 5'd5 || rf_wd !== 32'hDEAD_BEEF)
            $display("FAIL single_write got we=%b rd=%0d wd=%h want 1/5/deadbeef", rf_we, rf_rd, rf_wd);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (rf_we !== 1'b0 || rf_rd !== 5'd5 || rf_wd !== 32'hDEAD_BEEF)
            $display("FAIL single_idle got we=%b rd=%0d wd=%h want 0/5/deadbeef", rf_we, rf_rd, rf_wd);
        else pass_cnt++;
    endtask

    task automatic test_contention();
        int ai;
        int mi;
        logic exp_a;
        logic [DATA_W-1:0] exp_wd;
        ai = 0; mi = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_valid = (ai < 2); a_rd = 5'(1 + 2 * ai); a_wd = 32'hA000_0000 + 32'(1 + 2 * ai);
            m_valid = (mi < 2); m_rd = 5'(2 + 2 * mi); m_wd = 32'hB000_0000 + 32'(2 + 2 * mi);
            #1;
            exp_a = ((i % 2) == 0);
            exp_wd = (exp_a ? 32'hA000_0000 : 32'hB000_0000) + 32'(i + 1);
            total_cnt++;
            if (a_ready !== exp_a || m_ready !== !exp_a)
                $display("FAIL contention_grant%0d got a=%b m=%b want a=%b m=%b", i, a_ready, m_ready, exp_a, !exp_a);
            else pass_cnt++;
            tick();
            total_cnt++;
            if (rf_we !== 1'b1 || rf_rd !== 5'(i + 1) || rf_wd !== exp_wd)
                $display("FAIL contention_write%0d got we=%b rd=%0d wd=%h want 1/%0d/%h", i, rf_we, rf_rd, rf_wd, i + 1, exp_wd);
            else pass_cnt++;
            if (exp_a) ai++;
            else mi++;
        end
        idle_inputs();
        tick();
        total_cnt++;
        if (rf_we !== 1'b0) $display("FAIL contention_drain got we=%b want 0", rf_we);
        else pass_cnt++;
    endtask

    task automatic test_x0_write();
        issue_valid = 1'b1; issue_rd = 5'd9;
        tick();
        issue_valid = 1'b0;
        m_valid = 1'b1; m_rd = 5'd0; m_wd = 32'h0000_1234;
        #1;
        total_cnt++;
        if (m_ready !== 1'b1) $display("FAIL x0_ready got %b want 1", m_ready);
        else pass_cnt++;
        tick();
        m_valid = 1'b0;
        total_cnt++;
        if (rf_we !== 1'b0 || rf_rd !== 5'd4)
            $display("FAIL x0_no_write got we=%b rd=%0d want 0/4", rf_we, rf_rd);
        else pass_cnt++;
        total_cnt++;
        if (busy_mask !== 32'h0000_0200) $display("FAIL x0_busy got %h want 00000200", busy_mask);
        else pass_cnt++;
    endtask

    task automatic test_scoreboard();
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        issue_valid = 1'b0;
        total_cnt++;
        if (busy_mask !== 32'h0000_0280) $display("FAIL sb_set got %h want 00000280", busy_mask);
        else pass_cnt++;
        a_valid = 1'b1; a_rd = 5'd7; a_wd = 32'h0000_0077;
        tick();
        a_valid = 1'b0;
        total_cnt++;
        if (busy_mask !== 32'h0000_0200) $display("FAIL sb_clear got %h want 00000200", busy_mask);
        else pass_cnt++;
        total_cnt++;
        if (rf_we !== 1'b1 || rf_rd !== 5'd7 || rf_wd !== 32'h0000_0077)
            $display("FAIL sb_write got we=%b rd=%0d wd=%h want 1/7/00000077", rf_we, rf_rd, rf_wd);
        else pass_cnt++;
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        a_valid = 1'b1; a_rd = 5'd7; a_wd = 32'h0000_0777;
        tick();
        a_valid = 1'b0; issue_valid = 1'b0;
        total_cnt++;
        if (busy_mask !== 32'h0000_0280) $display("FAIL sb_set_wins got %h want 00000280", busy_mask);
        else pass_cnt++;
        m_valid = 1'b1; m_rd = 5'd9; m_wd = 32'h0000_0999;
        issue_valid = 1'b1; issue_rd = 5'd0;
        tick();
        m_valid = 1'b0; issue_valid = 1'b0;
        total_cnt++;
        if (busy_mask !== 32'h0000_0080) $display("FAIL sb_x0_issue got %h want 00000080", busy_mask);
        else pass_cnt++;
    endtask

    task automatic test_reset_midflight();
        a_valid = 1'b1; a_rd = 5'd12; a_wd = 32'hC0DE_0012;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (a_ready !== 1'b0) $display("FAIL midrst_ready got %b want 0", a_ready);
        else pass_cnt++;
        tick();
        rst = 1'b0;
        a_valid = 1'b0;
        total_cnt++;
        if (rf_we !== 1'b0 || busy_mask !== 32'h0)
            $display("FAIL midrst_state got we=%b busy=%h want 0/0", rf_we, busy_mask);
        else pass_cnt++;
        a_valid = 1'b1; a_rd = 5'd20; a_wd = 32'h0000_0020;
        m_valid = 1'b1; m_rd = 5'd21; m_wd = 32'h0000_0021;
        #1;
        total_cnt++;
        if (a_ready !== 1'b1 || m_ready !== 1'b0)
            $display("FAIL midrst_tie got a=%b m=%b want a=1 m=0", a_ready, m_ready);
        else pass_cnt++;
        tick();
        idle_inputs();
        total_cnt++;
        if (rf_we !== 1'b1 || rf_rd !== 5'd20)
            $display("FAIL midrst_write got we=%b rd=%0d want 1/20", rf_we, rf_rd);
        else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        a_rd = '0; a_wd = '0; m_rd = '0; m_wd = '0; issue_rd = '0;
        test_reset();
        test_single();
        test_contention();
        test_x0_write();
        test_scoreboard();
        test_reset_midflight();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
